wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Writeback arbiter between the four execution units (ALU, FPU, LSU, BRU) and the physical register file write ports.
- Each unit pushes a result packet into a private skid FIFO. A round-robin scheduler grants up to NUM_WR_PORTS FIFO heads per cycle.
- Each grant drives one registered regfile write port plus a ROB completion notification.
- The ROB and RAT need no knowledge of port count; units only see a valid/ready handshake.

Parameters:
- NUM_REQ, 4, number of requesting units (index 0=ALU, 1=FPU, 2=LSU, 3=BRU)
- NUM_WR_PORTS, 2, regfile write ports driven; 1..NUM_REQ
- FIFO_DEPTH, 2, entries per requester FIFO; power of two, >=2
- PHYS_REG_W, 7, physical register index width
- WORD_SIZE, 64, data width
- ROB_PTR_W, 6, ROB pointer width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush_in  in  1  pipeline flush; drop all buffered results
- req_valid_in  in  NUM_REQ  result valid per unit
- req_ready_out  out  NUM_REQ  FIFO can accept per unit
- req_preg_in  in  NUM_REQ*PHYS_REG_W  destination phys reg, unit i at slice i
- req_data_in  in  NUM_REQ*WORD_SIZE  result data
- req_rob_ptr_in  in  NUM_REQ*ROB_PTR_W  ROB entry of result
- wr_en_out  out  NUM_WR_PORTS  regfile write enable
- wr_index_out  out  NUM_WR_PORTS*PHYS_REG_W  regfile write index
- wr_data_out  out  NUM_WR_PORTS*WORD_SIZE  regfile write data
- done_valid_out  out  NUM_WR_PORTS  ROB completion valid (equal to wr_en_out)
- done_rob_ptr_out  out  NUM_WR_PORTS*ROB_PTR_W  ROB pointer completed

Behaviour:
- Reset (rst=1, async):
  - All FIFOs empty; rr_ptr=0.
  - wr_en_out, done_valid_out, wr_index_out, wr_data_out, done_rob_ptr_out all 0.
  - req_ready_out all 1 after rst deasserts.
  - Reset mid-operation discards buffered entries with no write.
- Handshake:
  - Push on edge when req_valid_in[i] & req_ready_out[i].
  - req_ready_out[i] = (count_i < FIFO_DEPTH), computed from registered count only, with no combinational path from grants or from valid.
  - A full FIFO that pops this cycle still refuses a push this cycle.
  - Per-requester order is preserved.
- Arbitration (combinational on registered FIFO heads, once per cycle):
  - Scan requesters rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - The first NUM_WR_PORTS non-empty FIFOs are granted, the k-th granted going to port k.
  - Granted heads pop at the edge, and the port output registers load at that same edge.
  - Ungranted ports load wr_en_out=0, with index/data/ptr held at the previous value.
- rr_ptr update:
  - If any grant: rr_ptr = (last granted index + 1) mod NUM_REQ.
  - If no grant: unchanged.
- Latency and throughput:
  - Packet pushed at edge E with no contention appears on the port during the cycle after edge E+1 (2 edges).
  - Each output is asserted for exactly one cycle.
  - Sustained throughput is min(NUM_WR_PORTS, non-empty FIFOs) per cycle.
- Flush:
  - flush_in=1 at edge F clears all FIFOs and sets rr_ptr=0.
  - Pushes and grants at F are discarded; wr_en_out=0 after F.
  - flush with simultaneous rst: rst wins.
- Wrap-around: FIFO pointers are log2(FIFO_DEPTH)+1 bits; full when MSBs differ and LSBs are equal.
- Duplicate preg across ports in one cycle is excluded by renaming and is not checked.

Optional Feature:
- Macro: WB_ARB_BYPASS_EN.
- When defined:
  - A requester whose FIFO is empty and whose req_valid_in=1 is a candidate this cycle, using input-side data.
  - If granted, the packet goes directly to the output register and is not enqueued. Latency is 1 edge: pushed at E, visible after E.
  - If not granted, it is enqueued normally.
  - req_ready_out is unchanged; no valid->ready path.
- When undefined: candidates are FIFO heads only; latency is 2 edges.

Test Plan:
1. Reset mid-stream: FIFO0 holds 2 entries, assert rst for 1 cycle -> wr_en_out=00 immediately; after release req_ready_out=1111; no write of the held entries ever appears.
2. Single result: req 0, preg=5, data=64'hDEAD, rob=3, pushed at edge E, all else idle -> after E+1: wr_en_out=01, wr_index[0]=5, wr_data[0]=DEAD, done_rob_ptr[0]=3, for one cycle only; rr_ptr=1.
3. Contention (NUM_WR_PORTS=2, rr_ptr=0): all 4 units push one packet at E ->
   - after E+1: ports carry units 0,1;
   - after E+2: ports carry units 2,3;
   - rr_ptr=0; no drops.
4. Backpressure (NUM_WR_PORTS=1, FIFO_DEPTH=2): all units hold valid continuously with distinct tags ->
   - req_ready_out drops per unit once its count reaches 2;
   - grant sequence is 0,1,2,3,0,...;
   - each unit's tags are written in push order, and none are lost or duplicated.
5. Flush: 3 entries buffered across units 1,2 with flush_in pulse at F -> wr_en_out=00 from F onward; req_ready_out=1111; new push at F+1 appears after F+2 from rr_ptr=0.
6. WB_ARB_BYPASS_EN defined: idle arbiter, unit 2 pushes preg=9 at E -> wr_en_out[0]=1 with index 9 after E; FIFO2 stays empty. Undefined: same write appears after E+1.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: execution-unit result handshake plus regfile/ROB write ports.
// Request lanes are flattened per unit; write lanes are flattened per port.
interface wb_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_WR_PORTS = 2,
  parameter int PHYS_REG_W   = 7,
  parameter int WORD_SIZE    = 64,
  parameter int ROB_PTR_W    = 6
);
  logic                              flush_in;
  logic [NUM_REQ-1:0]                req_valid_in;
  logic [NUM_REQ-1:0]                req_ready_out;
  logic [NUM_REQ*PHYS_REG_W-1:0]     req_preg_in;
  logic [NUM_REQ*WORD_SIZE-1:0]      req_data_in;
  logic [NUM_REQ*ROB_PTR_W-1:0]      req_rob_ptr_in;
  logic [NUM_WR_PORTS-1:0]           wr_en_out;
  logic [NUM_WR_PORTS*PHYS_REG_W-1:0] wr_index_out;
  logic [NUM_WR_PORTS*WORD_SIZE-1:0] wr_data_out;
  logic [NUM_WR_PORTS-1:0]           done_valid_out;
  logic [NUM_WR_PORTS*ROB_PTR_W-1:0] done_rob_ptr_out;

  modport master (
    output flush_in, req_valid_in, req_preg_in, req_data_in, req_rob_ptr_in,
    input  req_ready_out, wr_en_out, wr_index_out, wr_data_out, done_valid_out, done_rob_ptr_out
  );

  modport slave (
    input  flush_in, req_valid_in, req_preg_in, req_data_in, req_rob_ptr_in,
    output req_ready_out, wr_en_out, wr_index_out, wr_data_out, done_valid_out, done_rob_ptr_out
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-unit skid FIFOs, round-robin grant of up to NUM_WR_PORTS heads per cycle.
// Define WB_ARB_BYPASS_EN to let an empty FIFO's incoming packet compete directly (1-edge latency).
module wb_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_WR_PORTS = 2,
  parameter int FIFO_DEPTH   = 2,
  parameter int PHYS_REG_W   = 7,
  parameter int WORD_SIZE    = 64,
  parameter int ROB_PTR_W    = 6
) (
  input logic        clk,
  input logic        rst,
  wb_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PHYS_REG_W-1:0] fifo_preg [NUM_REQ][FIFO_DEPTH];
  logic [WORD_SIZE-1:0]  fifo_data [NUM_REQ][FIFO_DEPTH];
  logic [ROB_PTR_W-1:0]  fifo_rob  [NUM_REQ][FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr    [NUM_REQ];
  logic [PTR_W-1:0]      rd_ptr    [NUM_REQ];
  logic [RR_W-1:0]       rr_ptr;

  logic [NUM_REQ-1:0]    empty, full, push, pop, enq, cand, granted;
  logic [PHYS_REG_W-1:0] cand_preg [NUM_REQ];
  logic [WORD_SIZE-1:0]  cand_data [NUM_REQ];
  logic [ROB_PTR_W-1:0]  cand_rob  [NUM_REQ];
  logic [NUM_WR_PORTS-1:0] port_vld;
  logic [RR_W-1:0]       port_sel  [NUM_WR_PORTS];
  logic [RR_W-1:0]       rr_next;
  int unsigned           n_grant;
  int unsigned           scan_idx;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      empty[i]     = (wr_ptr[i] == rd_ptr[i]);
      full[i]      = (wr_ptr[i][PTR_W-1] != rd_ptr[i][PTR_W-1]) &&
                     (wr_ptr[i][IDX_W-1:0] == rd_ptr[i][IDX_W-1:0]);
      push[i]      = bus.req_valid_in[i] && !full[i];
      cand[i]      = !empty[i];
      cand_preg[i] = fifo_preg[i][rd_ptr[i][IDX_W-1:0]];
      cand_data[i] = fifo_data[i][rd_ptr[i][IDX_W-1:0]];
      cand_rob[i]  = fifo_rob[i][rd_ptr[i][IDX_W-1:0]];
`ifdef WB_ARB_BYPASS_EN
      if (empty[i]) begin
        cand[i]      = bus.req_valid_in[i];
        cand_preg[i] = bus.req_preg_in[i*PHYS_REG_W +: PHYS_REG_W];
        cand_data[i] = bus.req_data_in[i*WORD_SIZE +: WORD_SIZE];
        cand_rob[i]  = bus.req_rob_ptr_in[i*ROB_PTR_W +: ROB_PTR_W];
      end
`endif
    end
  end

  // Scan from rr_ptr, the k-th candidate found is routed to write port k.
  always_comb begin
    granted  = '0;
    port_vld = '0;
    rr_next  = rr_ptr;
    n_grant  = 0;
    scan_idx = 0;
    for (int unsigned k = 0; k < NUM_WR_PORTS; k++) port_sel[k] = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (cand[scan_idx] && n_grant < NUM_WR_PORTS) begin
        granted[scan_idx] = 1'b1;
        port_vld[n_grant] = 1'b1;
        port_sel[n_grant] = RR_W'(scan_idx);
        rr_next           = RR_W'((scan_idx + 1) % NUM_REQ);
        n_grant           = n_grant + 1;
      end
    end
  end

  // A granted empty FIFO is a bypassed packet: it leaves via the port and is never enqueued.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pop[i] = granted[i] && !empty[i];
      enq[i] = push[i] && !(granted[i] && empty[i]);
    end
  end

  assign bus.req_ready_out = ~full;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (enq[i]) begin
        fifo_preg[i][wr_ptr[i][IDX_W-1:0]] <= bus.req_preg_in[i*PHYS_REG_W +: PHYS_REG_W];
        fifo_data[i][wr_ptr[i][IDX_W-1:0]] <= bus.req_data_in[i*WORD_SIZE +: WORD_SIZE];
        fifo_rob[i][wr_ptr[i][IDX_W-1:0]]  <= bus.req_rob_ptr_in[i*ROB_PTR_W +: ROB_PTR_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      rr_ptr               <= '0;
      bus.wr_en_out        <= '0;
      bus.done_valid_out   <= '0;
      bus.wr_index_out     <= '0;
      bus.wr_data_out      <= '0;
      bus.done_rob_ptr_out <= '0;
    end else if (bus.flush_in) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      rr_ptr             <= '0;
      bus.wr_en_out      <= '0;
      bus.done_valid_out <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (enq[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
      end
      rr_ptr             <= rr_next;
      bus.wr_en_out      <= port_vld;
      bus.done_valid_out <= port_vld;
      for (int unsigned k = 0; k < NUM_WR_PORTS; k++) begin
        if (port_vld[k]) begin
          bus.wr_index_out[k*PHYS_REG_W +: PHYS_REG_W]    <= cand_preg[port_sel[k]];
          bus.wr_data_out[k*WORD_SIZE +: WORD_SIZE]       <= cand_data[port_sel[k]];
          bus.done_rob_ptr_out[k*ROB_PTR_W +: ROB_PTR_W]  <= cand_rob[port_sel[k]];
        end
      end
    end
  end
endmodule
